// File: rtl/keypad_entry_display.sv
// Matrix keypad scanner with press/release debounce, a shift-in hex digit buffer
// and a multiplexed digit output. Optional clear key: KEYPAD_CLEAR_KEY_EN.
module keypad_entry_display #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 50000,
    parameter int DEBOUNCE = 500000
) (
    input  logic            clk_50MHz,
    input  logic            rst,
    input  logic            en,
    input  logic [ROWS-1:0] swr,
    output logic [COLS-1:0] swc,
    output logic [3:0]      key_code,
    output logic            key_valid,
    output logic [2:0]      sel,
    output logic [3:0]      digit,
    output logic            blank,
    output logic [3:0]      count,
    output logic            full
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DB_W  = $clog2(DEBOUNCE);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE - 1);
    localparam logic [3:0]       COL_LAST = 4'(COLS - 1);
    localparam logic [2:0]       SEL_LAST = 3'(DIGITS - 1);
    localparam logic [3:0]       DIGITS_W = 4'(DIGITS);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_PRESS_DB = 2'd1,
        ST_HELD     = 2'd2,
        ST_REL_DB   = 2'd3
    } state_t;

    state_t                 state_q;
    logic [DIV_W-1:0]       div_q;
    logic [DB_W-1:0]        db_q;
    logic [3:0]             col_q;
    logic [COLS-1:0]        swc_q;
    logic [ROWS-1:0]        snap_q;
    logic [3:0]             code_q;
    logic [3:0]             key_code_q;
    logic                   key_valid_q;

    logic [4*DIGITS-1:0]    buf_q;
    logic [4*DIGITS-1:0]    buf_d;
    logic [3:0]             count_q;
    logic [3:0]             count_d;
    logic                   full_q;
    logic                   full_d;
    logic                   clear_hit_d;

    logic [DIV_W-1:0]       disp_div_q;
    logic [2:0]             sel_q;
    logic [3:0]             digit_q;
    logic                   blank_q;

    logic [3:0]             col_next_d;
    logic                   rows_idle_d;

    // Key code of the lowest-numbered closed row in the given column.
    function automatic logic [3:0] row_code(input logic [ROWS-1:0] rows, input logic [3:0] col);
        logic [3:0] code;
        code = 4'd0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (!rows[r]) begin
                code = 4'(r * COLS) + col;
            end
        end
        return code;
    endfunction

    function automatic logic [COLS-1:0] col_drive(input logic [3:0] col);
        logic [COLS-1:0] one;
        one = {{(COLS-1){1'b0}}, 1'b1};
        return ~(one << col);
    endfunction

    assign col_next_d  = (col_q == COL_LAST) ? 4'd0 : col_q + 4'd1;
    assign rows_idle_d = &swr;

    // Scanner FSM: column dwell, press debounce, hold, release debounce.
    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            state_q     <= ST_SCAN;
            div_q       <= '0;
            db_q        <= '0;
            col_q       <= 4'd0;
            swc_q       <= col_drive(4'd0);
            snap_q      <= '1;
            code_q      <= 4'd0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            case (state_q)
                ST_SCAN: begin
                    if (div_q == DIV_LAST) begin
                        div_q <= '0;
                        if (!rows_idle_d) begin
                            snap_q  <= swr;
                            code_q  <= row_code(swr, col_q);
                            db_q    <= '0;
                            state_q <= ST_PRESS_DB;
                        end else begin
                            col_q <= col_next_d;
                            swc_q <= col_drive(col_next_d);
                        end
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end
                ST_PRESS_DB: begin
                    if (swr == snap_q) begin
                        if (db_q == DB_LAST) begin
                            key_valid_q <= 1'b1;
                            key_code_q  <= code_q;
                            state_q     <= ST_HELD;
                        end else begin
                            db_q <= db_q + DB_W'(1);
                        end
                    end else begin
                        // Bounce: give up on this press and move on.
                        state_q <= ST_SCAN;
                        div_q   <= '0;
                        col_q   <= col_next_d;
                        swc_q   <= col_drive(col_next_d);
                    end
                end
                ST_HELD: begin
                    if (rows_idle_d) begin
                        db_q    <= '0;
                        state_q <= ST_REL_DB;
                    end
                end
                ST_REL_DB: begin
                    if (!rows_idle_d) begin
                        state_q <= ST_HELD;
                    end else if (db_q == DB_LAST) begin
                        state_q <= ST_SCAN;
                        div_q   <= '0;
                        col_q   <= col_next_d;
                        swc_q   <= col_drive(col_next_d);
                    end else begin
                        db_q <= db_q + DB_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_SCAN;
                end
            endcase
        end
    end

`ifdef KEYPAD_CLEAR_KEY_EN
    localparam logic [3:0] CLEAR_CODE = 4'(ROWS * COLS - 1);
    assign clear_hit_d = key_valid_q && en && (key_code_q == CLEAR_CODE);
`else
    assign clear_hit_d = 1'b0;
`endif

    // Buffer next state: clear, shift in the accepted key, or hold.
    always_comb begin
        buf_d   = buf_q;
        count_d = count_q;
        if (clear_hit_d) begin
            buf_d   = '0;
            count_d = 4'd0;
        end else if (key_valid_q && en && !full_q) begin
            buf_d   = {buf_q[4*DIGITS-5:0], key_code_q};
            count_d = count_q + 4'd1;
        end else begin
            buf_d   = buf_q;
            count_d = count_q;
        end
        full_d = (count_d == DIGITS_W);
    end

    // Digit buffer and entry count registers.
    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            buf_q   <= '0;
            count_q <= 4'd0;
            full_q  <= 1'b0;
        end else begin
            buf_q   <= buf_d;
            count_q <= count_d;
            full_q  <= full_d;
        end
    end

    // Display multiplexer: digit and blank lag sel by one cycle.
    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            disp_div_q <= '0;
            sel_q      <= 3'd0;
            digit_q    <= 4'd0;
            blank_q    <= 1'b1;
        end else begin
            if (disp_div_q == DIV_LAST) begin
                disp_div_q <= '0;
                sel_q      <= (sel_q == SEL_LAST) ? 3'd0 : sel_q + 3'd1;
            end else begin
                disp_div_q <= disp_div_q + DIV_W'(1);
            end
            digit_q <= buf_q[{sel_q, 2'b00} +: 4];
            blank_q <= ({1'b0, sel_q} >= count_q);
        end
    end

    assign swc       = swc_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign sel       = sel_q;
    assign digit     = digit_q;
    assign blank     = blank_q;
    assign count     = count_q;
    assign full      = full_q;

endmodule

// File: tb/tb_keypad_entry_display.sv
// Directed bench for keypad_entry_display with a behavioural 4x4 key matrix.
module tb_keypad_entry_display;

    localparam int ROWS     = 4;
    localparam int COLS     = 4;
    localparam int DIGITS   = 8;
    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 8;

    logic       clk_50MHz = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] swr;
    logic [3:0] swc;
    logic [3:0] key_code;
    logic       key_valid;
    logic [2:0] sel;
    logic [3:0] digit;
    logic       blank;
    logic [3:0] count;
    logic       full;

    int total = 0;
    int bad   = 0;
    int kv_cnt = 0;

    logic       press_on = 1'b0;
    logic [1:0] press_row = 2'd0;
    logic [1:0] press_col = 2'd0;

    keypad_entry_display #(
        .ROWS(ROWS), .COLS(COLS), .DIGITS(DIGITS),
        .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)
    ) dut (
        .clk_50MHz(clk_50MHz), .rst(rst), .en(en), .swr(swr), .swc(swc),
        .key_code(key_code), .key_valid(key_valid), .sel(sel), .digit(digit),
        .blank(blank), .count(count), .full(full)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    // Key matrix: the pressed key pulls its row low while its column is driven.
    always_comb begin
        swr = 4'hF;
        if (press_on && (swc[press_col] == 1'b0)) begin
            swr[press_row] = 1'b0;
        end
    end

    always @(negedge clk_50MHz) begin
        if (key_valid === 1'b1) kv_cnt++;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        press_on = 1'b0;
        en = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk_50MHz);
        rst = 1'b0;
    endtask

    task automatic wait_swc(input logic [3:0] want);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk_50MHz);
            if (swc == want) found = 1'b1;
        end
        check_val($sformatf("swc_reach_%0h", want), 32'(found), 32'd1);
    endtask

    task automatic press_key(input logic [3:0] code);
        bit seen;
        int kv0;
        kv0 = kv_cnt;
        press_row = code[3:2];
        press_col = code[1:0];
        press_on = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk_50MHz);
            if (key_valid) seen = 1'b1;
        end
        check_val($sformatf("key%0d_seen", code), 32'(seen), 32'd1);
        check_val($sformatf("key%0d_code", code), 32'(key_code), 32'(code));
        repeat (3) @(negedge clk_50MHz);
        press_on = 1'b0;
        repeat (DEBOUNCE + 4) @(negedge clk_50MHz);
        check_val($sformatf("key%0d_pulses", code), 32'(kv_cnt - kv0), 32'd1);
    endtask

    task automatic read_digit(input int k, output logic [3:0] d, output logic b);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk_50MHz);
            if (sel == 3'(k)) found = 1'b1;
        end
        @(negedge clk_50MHz);
        d = digit;
        b = blank;
        check_val($sformatf("sel_reach_%0d", k), 32'(found), 32'd1);
    endtask

    initial begin
        logic [3:0] d;
        logic       b;
        int         lat;
        int         kv0;

        // Reset values
        en = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk_50MHz);
        check_val("rst_swc", 32'(swc), 32'hE);
        check_val("rst_key_code", 32'(key_code), 32'd0);
        check_val("rst_key_valid", 32'(key_valid), 32'd0);
        check_val("rst_sel", 32'(sel), 32'd0);
        check_val("rst_digit", 32'(digit), 32'd0);
        check_val("rst_blank", 32'(blank), 32'd1);
        check_val("rst_count", 32'(count), 32'd0);
        check_val("rst_full", 32'(full), 32'd0);

        // Row 2 / column 1 press: latency, code 9, single pulse
        press_row = 2'd2;
        press_col = 2'd1;
        press_on = 1'b1;
        rst = 1'b0;
        wait_swc(4'b1101);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_50MHz);
            lat++;
            if (key_valid) break;
        end
        check_val("t1_latency", 32'(lat), 32'(SCAN_DIV + DEBOUNCE));
        check_val("t1_key_code", 32'(key_code), 32'd9);
        @(negedge clk_50MHz);
        check_val("t1_pulse_width", 32'(key_valid), 32'd0);
        check_val("t1_count", 32'(count), 32'd1);
        check_val("t1_full", 32'(full), 32'd0);
        repeat (3) @(negedge clk_50MHz);
        press_on = 1'b0;
        repeat (DEBOUNCE + 6) @(negedge clk_50MHz);
        check_val("t1_pulses", 32'(kv_cnt), 32'd1);
        read_digit(0, d, b);
        check_val("t1_digit0", 32'(d), 32'd9);
        check_val("t1_blank0", 32'(b), 32'd0);
        for (int k = 1; k < DIGITS; k++) begin
            read_digit(k, d, b);
            check_val($sformatf("t1_blank%0d", k), 32'(b), 32'd1);
        end

        // Keys 1,2,3 shift in with the newest at index 0
        do_reset();
        press_key(4'd1);
        press_key(4'd2);
        press_key(4'd3);
        check_val("t2_count", 32'(count), 32'd3);
        read_digit(0, d, b);
        check_val("t2_digit0", 32'(d), 32'd3);
        read_digit(1, d, b);
        check_val("t2_digit1", 32'(d), 32'd2);
        read_digit(2, d, b);
        check_val("t2_digit2", 32'(d), 32'd1);
        check_val("t2_blank2", 32'(b), 32'd0);
        read_digit(3, d, b);
        check_val("t2_blank3", 32'(b), 32'd1);

        // Fill 8 digits with 4..11, then a 9th key is rejected
        do_reset();
        for (int k = 0; k < DIGITS; k++) press_key(4'(k + 4));
        check_val("t3_count_full", 32'(count), 32'd8);
        check_val("t3_full", 32'(full), 32'd1);
        press_key(4'd2);
        check_val("t3_count_after9", 32'(count), 32'd8);
        check_val("t3_full_after9", 32'(full), 32'd1);
        read_digit(0, d, b);
        check_val("t3_digit0", 32'(d), 32'd11);
        read_digit(7, d, b);
        check_val("t3_digit7", 32'(d), 32'd4);
        check_val("t3_blank7", 32'(b), 32'd0);

        // Bounce during press debounce: no pulse, scanning moves to column 3
        do_reset();
        kv0 = kv_cnt;
        press_row = 2'd1;
        press_col = 2'd2;
        press_on = 1'b1;
        wait_swc(4'b1011);
        repeat (SCAN_DIV) @(negedge clk_50MHz);
        for (int n = 0; n < 8; n++) begin
            press_on = n[0];
            @(negedge clk_50MHz);
            if (n == 0) check_val("t4_next_col", 32'(swc), 32'h7);
        end
        press_on = 1'b0;
        repeat (30) @(negedge clk_50MHz);
        check_val("t4_no_pulse", 32'(kv_cnt - kv0), 32'd0);
        check_val("t4_count", 32'(count), 32'd0);

        // en low: key 5 reported but not stored
        do_reset();
        en = 1'b0;
        press_key(4'd5);
        check_val("t5_count_en0", 32'(count), 32'd0);
        en = 1'b1;

        // Reset in the middle of a press debounce
        press_key(4'd3);
        check_val("t5_count_pre", 32'(count), 32'd1);
        kv0 = kv_cnt;
        press_row = 2'd0;
        press_col = 2'd2;
        press_on = 1'b1;
        wait_swc(4'b1011);
        repeat (SCAN_DIV + 2) @(negedge clk_50MHz);
        rst = 1'b1;
        #1;
        check_val("t5_rst_swc", 32'(swc), 32'hE);
        check_val("t5_rst_key_code", 32'(key_code), 32'd0);
        check_val("t5_rst_key_valid", 32'(key_valid), 32'd0);
        check_val("t5_rst_count", 32'(count), 32'd0);
        check_val("t5_rst_full", 32'(full), 32'd0);
        check_val("t5_rst_sel", 32'(sel), 32'd0);
        check_val("t5_rst_digit", 32'(digit), 32'd0);
        check_val("t5_rst_blank", 32'(blank), 32'd1);
        press_on = 1'b0;
        repeat (DEBOUNCE + 4) @(negedge clk_50MHz);
        check_val("t5_rst_no_pulse", 32'(kv_cnt - kv0), 32'd0);
        rst = 1'b0;

        // Key 15 on a full buffer: clear key when enabled, else rejected
        do_reset();
        for (int k = 1; k <= DIGITS; k++) press_key(4'(k));
        check_val("t6_full_pre", 32'(full), 32'd1);
        press_key(4'd15);
`ifdef KEYPAD_CLEAR_KEY_EN
        check_val("t6_count", 32'(count), 32'd0);
        check_val("t6_full", 32'(full), 32'd0);
        for (int k = 0; k < DIGITS; k++) begin
            read_digit(k, d, b);
            check_val($sformatf("t6_blank%0d", k), 32'(b), 32'd1);
        end
`else
        check_val("t6_count", 32'(count), 32'd8);
        check_val("t6_full", 32'(full), 32'd1);
        read_digit(0, d, b);
        check_val("t6_digit0", 32'(d), 32'd8);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
